block_scan_counter: RTL and testbench

Parametrised address generator that walks a W×H image as a sequence of BLK×BLK tiles and emits one pixel address per cycle, for the DCT and quantiser stages of the compression pipeline. It adds start/busy/done control, a stall input, terminal-count flags and a row- or column-major scan inside each tile. Column-major scan feeds the transpose pass of the 2-D DCT.

---
 rtl/block_scan_counter_pkg.sv | 12 +
 rtl/block_scan_counter_mod_counter.sv | 20 ++
 rtl/block_scan_counter.sv | 82 ++++++++
 tb/tb_block_scan_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/block_scan_counter_pkg.sv
// img_comp_pkg: shared scan-mode constants, FSM states and width helper
package img_comp_pkg;
  localparam logic SCAN_ROW = 1'b0;
  localparam logic SCAN_COL = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/block_scan_counter_mod_counter.sv
// mod_counter: modulus-M counter with increment enable, sync clear and wrap flag
module mod_counter #(
  parameter int M = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic         o_wrap
);
  logic [W-1:0] r_q;
  assign o_q    = r_q;
  assign o_wrap = i_inc && (r_q == W'(M - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc) r_q <= o_wrap ? '0 : r_q + W'(1);
endmodule

// File: rtl/block_scan_counter.sv
// block_scan_counter: tiled BLKxBLK pixel address generator with row/column-major inner scan
module block_scan_counter
  import img_comp_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int BLK    = 8,
  parameter int ADDR_W = clog2(IMG_W * IMG_H),
  localparam int BW = clog2(BLK),
  localparam int XW = clog2(IMG_W / BLK),
  localparam int YW = clog2(IMG_H / BLK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr,
  output logic [BW-1:0]     row,
  output logic [BW-1:0]     col,
  output logic [XW-1:0]     blk_x,
  output logic [YW-1:0]     blk_y,
  output logic              valid,
  output logic              blk_first,
  output logic              blk_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);
  state_t r_state, w_next;
  logic r_mode;
  logic w_en, w_clr;
  logic [BW-1:0] w_fast, w_slow;
  logic w_fast_wrap, w_slow_wrap, w_bx_wrap, w_by_wrap;
  logic [ADDR_W-1:0] w_y, w_x, w_addr;
  assign w_en  = (r_state == RUN) && !stall;
  assign w_clr = (r_state == IDLE) && start;
  mod_counter #(.M(BLK), .W(BW)) u_fast (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_en), .o_q(w_fast), .o_wrap(w_fast_wrap)
  );
  mod_counter #(.M(BLK), .W(BW)) u_slow (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_fast_wrap), .o_q(w_slow), .o_wrap(w_slow_wrap)
  );
  mod_counter #(.M(IMG_W / BLK), .W(XW)) u_bx (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_slow_wrap), .o_q(blk_x), .o_wrap(w_bx_wrap)
  );
  mod_counter #(.M(IMG_H / BLK), .W(YW)) u_by (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_bx_wrap), .o_q(blk_y), .o_wrap(w_by_wrap)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= SCAN_ROW;
    end else begin
      r_state <= w_next;
      if (w_clr) r_mode <= mode;
    end
  // the blk_y wrap fires only on the advancing cycle of the frame's last pixel
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && start) ? RUN :
             (r_state == RUN && w_by_wrap) ? DONE :
             (r_state == DONE) ? IDLE : r_state;
  end
  assign row        = (r_mode == SCAN_COL) ? w_fast : w_slow;
  assign col        = (r_mode == SCAN_COL) ? w_slow : w_fast;
  assign valid      = (r_state == RUN);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign blk_first  = valid && (w_fast == '0) && (w_slow == '0);
  assign blk_last   = valid && (w_fast == BW'(BLK - 1)) && (w_slow == BW'(BLK - 1));
  assign frame_last = blk_last && (blk_x == XW'(IMG_W / BLK - 1)) && (blk_y == YW'(IMG_H / BLK - 1));
  // BLK is a power of two, so tile/offset concatenate; y*IMG_W is a constant shift-add
  assign w_y = ADDR_W'({blk_y, row});
  assign w_x = ADDR_W'({blk_x, col});
  always_comb begin
    w_addr = w_x;
    for (int i = 0; i < 31; i++)
      if (IMG_W[i]) w_addr = w_addr + (w_y << i);
  end
  assign addr = w_addr;
endmodule

// File: tb/tb_block_scan_counter.sv
// tb_block_scan_counter: directed checks of tiled scan order, stall, start handling and reset abort
module tb_block_scan_counter;
  logic clk = 0, rst = 0, start = 0, mode = 0, stall = 0;
  logic [11:0] addr;
  logic [2:0] row, col, blk_x, blk_y;
  logic valid, blk_first, blk_last, frame_last, busy, done;
  logic s_start = 0, s_mode = 0, s_stall = 0;
  logic [8:0] s_addr;
  logic [1:0] s_row, s_col, s_by;
  logic [2:0] s_bx;
  logic s_valid, s_first, s_last, s_flast, s_busy, s_done;
  int n_vec = 0, n_err = 0, lat;

  block_scan_counter dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall), .addr(addr),
    .row(row), .col(col), .blk_x(blk_x), .blk_y(blk_y), .valid(valid), .blk_first(blk_first),
    .blk_last(blk_last), .frame_last(frame_last), .busy(busy), .done(done)
  );
  block_scan_counter #(.IMG_W(32), .IMG_H(16), .BLK(4)) dut_ns (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .stall(s_stall), .addr(s_addr),
    .row(s_row), .col(s_col), .blk_x(s_bx), .blk_y(s_by), .valid(s_valid), .blk_first(s_first),
    .blk_last(s_last), .frame_last(s_flast), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int k, input logic m, input int w, input int b);
    int tile, p, r, c;
    tile = k / (b * b);
    p = k % (b * b);
    r = m ? p % b : p / b;
    c = m ? p / b : p % b;
    return ((tile / (w / b)) * b + r) * w + (tile % (w / b)) * b + c;
  endfunction

  task automatic run_frame(input logic m, input int stall_k, input int pulse_k, input int abort_k,
                           output int lt);
    int k, p;
    k = 0;
    start = 1;
    mode = m;
    tick;
    start = 0;
    lt = 1;
    while (!done && lt < 5000) begin
      p = k % 64;
      check("valid", valid, 1);
      check("addr", addr, exp_addr(k, m, 64, 8));
      check("row", row, m ? p % 8 : p / 8);
      check("col", col, m ? p / 8 : p % 8);
      check("blk_first", blk_first, p == 0);
      check("blk_last", blk_last, p == 63);
      check("frame_last", frame_last, k == 4095);
      if (m == 0 && k == 8) check("m0_k8", addr, 64);
      if (m == 0 && k == 64) begin
        check("m0_k64_addr", addr, 8);
        check("m0_k64_bx", blk_x, 1);
      end
      if (m == 0 && k == 4032) check("m0_last_tile", addr, 3640);
      if (m == 1 && k == 1) check("m1_k1", addr, 64);
      if (m == 1 && k == 8) check("m1_k8", addr, 1);
      if (m == 1 && k == 63) check("m1_blk_last_addr", addr, 455);
      if (k == 4095) check("last_addr", addr, 4095);
      start = (k == pulse_k);
      if (k == pulse_k) mode = ~m;
      if (k == abort_k) begin
        #2 rst = 0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 0);
        check("abort_bx", blk_x, 0);
        repeat (3) begin
          tick;
          check("abort_done", done, 0);
        end
        rst = 1;
        return;
      end
      if (k == stall_k) begin
        stall = 1;
        repeat (5) begin
          tick;
          lt++;
          check("stall_addr", addr, 448);
          check("stall_valid", valid, 1);
          check("stall_row", row, 7);
        end
        stall = 0;
        tick;
        lt++;
        k++;
        check("after_stall", addr, 449);
        continue;
      end
      tick;
      lt++;
      k++;
    end
    check("done", done, 1);
    check("pixels", k, 4096);
    check("busy_in_done", busy, 1);
    check("valid_in_done", valid, 0);
  endtask

  initial begin
    repeat (2) tick;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    check("rst_ns_addr", s_addr, 0);
    rst = 1;
    tick;
    run_frame(0, -1, -1, 100, lat);
    tick;
    check("post_abort_idle", busy, 0);
    run_frame(0, -1, 100, -1, lat);
    check("latency_m0", lat, 4097);
    start = 1;
    mode = 1;
    tick;
    start = 0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
    run_frame(1, -1, -1, -1, lat);
    check("latency_m1", lat, 4097);
    tick;
    run_frame(0, 56, -1, -1, lat);
    check("latency_stall", lat, 4102);
    tick;
    s_start = 1;
    tick;
    s_start = 0;
    for (int k = 0; k < 512; k++) begin
      check("ns_addr", s_addr, exp_addr(k, 0, 32, 4));
      if (k == 128) begin
        check("ns_row1_addr", s_addr, 128);
        check("ns_row1_by", s_by, 1);
        check("ns_row1_bx", s_bx, 0);
        check("ns_row1_first", s_first, 1);
        check("ns_row1_rc", {s_row, s_col}, 0);
      end
      if (k == 511) begin
        check("ns_last_addr", s_addr, 511);
        check("ns_frame_last", s_flast, 1);
        check("ns_blk_last", s_last, 1);
      end
      tick;
    end
    check("ns_done", s_done, 1);
    check("ns_busy", s_busy, 1);
    check("ns_valid", s_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
